// File: rtl/axi4l_addr_router.sv
// AXI4-Lite 1-master / 2-slave address router with local decode-error and
// timeout responses, so the upstream bridge always receives a response.
module axi4l_addr_router #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [31:0] S0_BASE        = 32'h0000_1000,
    parameter logic [31:0] S0_SIZE        = 32'h0000_1000,
    parameter logic [31:0] S1_BASE        = 32'h0000_2000,
    parameter logic [31:0] S1_SIZE        = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rvalid,
    input  logic                    s_rready,
    output logic [ADDR_WIDTH-1:0]   m0_awaddr,
    output logic                    m0_awvalid,
    input  logic                    m0_awready,
    output logic [DATA_WIDTH-1:0]   m0_wdata,
    output logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic                    m0_wvalid,
    input  logic                    m0_wready,
    input  logic [1:0]              m0_bresp,
    input  logic                    m0_bvalid,
    output logic                    m0_bready,
    output logic [ADDR_WIDTH-1:0]   m0_araddr,
    output logic                    m0_arvalid,
    input  logic                    m0_arready,
    input  logic [DATA_WIDTH-1:0]   m0_rdata,
    input  logic [1:0]              m0_rresp,
    input  logic                    m0_rvalid,
    output logic                    m0_rready,
    output logic [ADDR_WIDTH-1:0]   m1_awaddr,
    output logic                    m1_awvalid,
    input  logic                    m1_awready,
    output logic [DATA_WIDTH-1:0]   m1_wdata,
    output logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_wvalid,
    input  logic                    m1_wready,
    input  logic [1:0]              m1_bresp,
    input  logic                    m1_bvalid,
    output logic                    m1_bready,
    output logic [ADDR_WIDTH-1:0]   m1_araddr,
    output logic                    m1_arvalid,
    input  logic                    m1_arready,
    input  logic [DATA_WIDTH-1:0]   m1_rdata,
    input  logic [1:0]              m1_rresp,
    input  logic                    m1_rvalid,
    output logic                    m1_rready,
    output logic                    busy,
    output logic [7:0]              decerr_count,
    output logic [7:0]              timeout_count
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] S0_MASK   = ~ADDR_WIDTH'(S0_SIZE - 32'd1);
    localparam logic [ADDR_WIDTH-1:0] S1_MASK   = ~ADDR_WIDTH'(S1_SIZE - 32'd1);
    localparam logic [ADDR_WIDTH-1:0] S0_BASE_A = ADDR_WIDTH'(S0_BASE);
    localparam logic [ADDR_WIDTH-1:0] S1_BASE_A = ADDR_WIDTH'(S1_BASE);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]            RESP_SLVERR = 2'b10;
    localparam logic [1:0]            RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_ADDR   = 4'd1,
        ST_WR_DATA   = 4'd2,
        ST_WR_RESP   = 4'd3,
        ST_RD_ADDR   = 4'd4,
        ST_RD_DATA   = 4'd5,
        ST_ERR_WDATA = 4'd6,
        ST_ERR_BRESP = 4'd7,
        ST_ERR_RRESP = 4'd8
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t                  state_r, next_state_s;
    logic [ADDR_WIDTH-1:0]   addr_r, req_addr_s;
    logic                    tgt_r, last_grant_r;
    logic [1:0]              err_code_r;
    logic [TMO_W-1:0]        tmo_cnt_r;
    logic                    grant_wr_s, grant_rd_s, hit0_s, hit1_s, req_hit_s, dec_take_s;
    logic                    tmo_en_s, tmo_fire_s, tmo_take_s;
    logic                    sel_awready_s, sel_wready_s, sel_bvalid_s, sel_arready_s, sel_rvalid_s;
    logic [1:0]              sel_bresp_s, sel_rresp_s;
    logic [DATA_WIDTH-1:0]   sel_rdata_s;
    logic                    ph_aw_s, ph_w_s, ph_b_s, ph_ar_s, ph_r_s;

    // last_grant_r = 1 means the previous grant went to read, so contention favours write
    assign grant_wr_s = (state_r == ST_IDLE) & s_awvalid & (~s_arvalid | last_grant_r);
    assign grant_rd_s = (state_r == ST_IDLE) & s_arvalid & (~s_awvalid | ~last_grant_r);
    assign req_addr_s = grant_wr_s ? s_awaddr : s_araddr;
    assign hit0_s     = ((req_addr_s & S0_MASK) == S0_BASE_A);
    assign hit1_s     = ((req_addr_s & S1_MASK) == S1_BASE_A);
    assign req_hit_s  = hit0_s | hit1_s;
    assign dec_take_s = (grant_wr_s | grant_rd_s) & ~req_hit_s;

    assign sel_awready_s = tgt_r ? m1_awready : m0_awready;
    assign sel_wready_s  = tgt_r ? m1_wready  : m0_wready;
    assign sel_bvalid_s  = tgt_r ? m1_bvalid  : m0_bvalid;
    assign sel_bresp_s   = tgt_r ? m1_bresp   : m0_bresp;
    assign sel_arready_s = tgt_r ? m1_arready : m0_arready;
    assign sel_rvalid_s  = tgt_r ? m1_rvalid  : m0_rvalid;
    assign sel_rresp_s   = tgt_r ? m1_rresp   : m0_rresp;
    assign sel_rdata_s   = tgt_r ? m1_rdata   : m0_rdata;

    assign tmo_fire_s = tmo_en_s & (tmo_cnt_r == TMO_LAST);
    assign busy       = (state_r != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= next_state_s;
    end

    // Next-state logic; a completed handshake always takes priority over timeout
    always_comb begin
        next_state_s = state_r;
        tmo_take_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (grant_wr_s)      next_state_s = req_hit_s ? ST_WR_ADDR : ST_ERR_WDATA;
                else if (grant_rd_s) next_state_s = req_hit_s ? ST_RD_ADDR : ST_ERR_RRESP;
                else                 next_state_s = ST_IDLE;
            end
            ST_WR_ADDR: begin
                if (sel_awready_s)   next_state_s = ST_WR_DATA;
                else if (tmo_fire_s) begin next_state_s = ST_ERR_WDATA; tmo_take_s = 1'b1; end
                else                 next_state_s = ST_WR_ADDR;
            end
            ST_WR_DATA: begin
                if (s_wvalid & sel_wready_s) next_state_s = ST_WR_RESP;
                else if (tmo_fire_s) begin next_state_s = ST_ERR_WDATA; tmo_take_s = 1'b1; end
                else                 next_state_s = ST_WR_DATA;
            end
            ST_WR_RESP: begin
                if (sel_bvalid_s & s_bready) next_state_s = ST_IDLE;
                else if (tmo_fire_s) begin next_state_s = ST_ERR_BRESP; tmo_take_s = 1'b1; end
                else                 next_state_s = ST_WR_RESP;
            end
            ST_RD_ADDR: begin
                if (sel_arready_s)   next_state_s = ST_RD_DATA;
                else if (tmo_fire_s) begin next_state_s = ST_ERR_RRESP; tmo_take_s = 1'b1; end
                else                 next_state_s = ST_RD_ADDR;
            end
            ST_RD_DATA: begin
                if (sel_rvalid_s & s_rready) next_state_s = ST_IDLE;
                else if (tmo_fire_s) begin next_state_s = ST_ERR_RRESP; tmo_take_s = 1'b1; end
                else                 next_state_s = ST_RD_DATA;
            end
            ST_ERR_WDATA: next_state_s = s_wvalid ? ST_ERR_BRESP : ST_ERR_WDATA;
            ST_ERR_BRESP: next_state_s = s_bready ? ST_IDLE : ST_ERR_BRESP;
            ST_ERR_RRESP: next_state_s = s_rready ? ST_IDLE : ST_ERR_RRESP;
            default:      next_state_s = ST_IDLE;
        endcase
    end

    // Upstream-facing outputs per state
    always_comb begin
        s_awready = 1'b0;
        s_arready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bresp   = 2'b00;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = 2'b00;
        case (state_r)
            ST_IDLE:      begin s_awready = grant_wr_s; s_arready = grant_rd_s; end
            ST_WR_DATA:   s_wready = sel_wready_s;
            ST_WR_RESP:   begin s_bvalid = sel_bvalid_s; s_bresp = sel_bresp_s; end
            ST_RD_DATA:   begin s_rvalid = sel_rvalid_s; s_rdata = sel_rdata_s; s_rresp = sel_rresp_s; end
            ST_ERR_WDATA: s_wready = 1'b1;
            ST_ERR_BRESP: begin s_bvalid = 1'b1; s_bresp = err_code_r; end
            ST_ERR_RRESP: begin s_rvalid = 1'b1; s_rresp = err_code_r; end
            default:      s_awready = 1'b0;
        endcase
    end

    // Timeout enable: address phases always count, data/response phases count while the slave stalls
    always_comb begin
        tmo_en_s = 1'b0;
        case (state_r)
            ST_WR_ADDR: tmo_en_s = 1'b1;
            ST_RD_ADDR: tmo_en_s = 1'b1;
            ST_WR_DATA: tmo_en_s = ~sel_wready_s;
            ST_WR_RESP: tmo_en_s = ~sel_bvalid_s;
            ST_RD_DATA: tmo_en_s = ~sel_rvalid_s;
            default:    tmo_en_s = 1'b0;
        endcase
    end

    // Timeout counter, cleared on every state change
    always_ff @(posedge clk) begin
        if (rst)                          tmo_cnt_r <= '0;
        else if (next_state_s != state_r) tmo_cnt_r <= '0;
        else if (tmo_en_s)                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        else                              tmo_cnt_r <= tmo_cnt_r;
    end

    // Transaction context captured at grant; slave 0 wins overlapping windows
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r       <= '0;
            tgt_r        <= 1'b0;
            last_grant_r <= 1'b1;
            err_code_r   <= 2'b00;
        end else if (grant_wr_s | grant_rd_s) begin
            addr_r       <= req_addr_s;
            tgt_r        <= ~hit0_s;
            last_grant_r <= grant_rd_s;
            err_code_r   <= RESP_DECERR;
        end else if (tmo_take_s) begin
            err_code_r   <= RESP_SLVERR;
        end
    end

    // Saturating error statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            decerr_count  <= 8'd0;
            timeout_count <= 8'd0;
        end else begin
            decerr_count  <= dec_take_s ? sat_inc(decerr_count)  : decerr_count;
            timeout_count <= tmo_take_s ? sat_inc(timeout_count) : timeout_count;
        end
    end

    assign ph_aw_s = (state_r == ST_WR_ADDR);
    assign ph_w_s  = (state_r == ST_WR_DATA);
    assign ph_b_s  = (state_r == ST_WR_RESP);
    assign ph_ar_s = (state_r == ST_RD_ADDR);
    assign ph_r_s  = (state_r == ST_RD_DATA);

    assign m0_awvalid = ph_aw_s & ~tgt_r;
    assign m0_awaddr  = (ph_aw_s & ~tgt_r) ? addr_r  : '0;
    assign m0_wvalid  = ph_w_s & ~tgt_r & s_wvalid;
    assign m0_wdata   = (ph_w_s & ~tgt_r) ? s_wdata : '0;
    assign m0_wstrb   = (ph_w_s & ~tgt_r) ? s_wstrb : '0;
    assign m0_bready  = ph_b_s & ~tgt_r & s_bready;
    assign m0_arvalid = ph_ar_s & ~tgt_r;
    assign m0_araddr  = (ph_ar_s & ~tgt_r) ? addr_r : '0;
    assign m0_rready  = ph_r_s & ~tgt_r & s_rready;

    assign m1_awvalid = ph_aw_s & tgt_r;
    assign m1_awaddr  = (ph_aw_s & tgt_r) ? addr_r  : '0;
    assign m1_wvalid  = ph_w_s & tgt_r & s_wvalid;
    assign m1_wdata   = (ph_w_s & tgt_r) ? s_wdata : '0;
    assign m1_wstrb   = (ph_w_s & tgt_r) ? s_wstrb : '0;
    assign m1_bready  = ph_b_s & tgt_r & s_bready;
    assign m1_arvalid = ph_ar_s & tgt_r;
    assign m1_araddr  = (ph_ar_s & tgt_r) ? addr_r : '0;
    assign m1_rready  = ph_r_s & tgt_r & s_rready;

endmodule

// File: tb/tb_axi4l_addr_router.sv
// Directed bench for axi4l_addr_router: vector table of whole transactions
// plus hand-written sequences for reset, arbitration and counter saturation.
module tb_axi4l_addr_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_awaddr = '0, s_araddr = '0, s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m1_awaddr, m1_wdata, m1_araddr;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready;
    logic        m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
    logic        m0_awready = 1'b0, m0_wready = 1'b0, m0_bvalid = 1'b0, m0_arready = 1'b0, m0_rvalid = 1'b0;
    logic        m1_awready = 1'b0, m1_wready = 1'b0, m1_bvalid = 1'b0, m1_arready = 1'b0, m1_rvalid = 1'b0;
    logic [1:0]  m0_bresp = 2'b00, m0_rresp = 2'b00, m1_bresp = 2'b00, m1_rresp = 2'b00;
    logic [31:0] m0_rdata = '0, m1_rdata = '0;
    logic        busy;
    logic [7:0]  decerr_count, timeout_count;

    int checks = 0;
    int failures = 0;

    axi4l_addr_router #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
        .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .busy(busy), .decerr_count(decerr_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          waits;
        logic        stall;
        logic [1:0]  sresp;
        logic [31:0] sdata;
        logic [1:0]  exp_hit;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_avc;
        logic [7:0]  exp_dec;
        logic [7:0]  exp_tmo;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Master + reactive slave for one transaction; both slaves behave alike
    task automatic run_txn(input int idx, input vec_t v);
        bit          pb[2], pr[2];
        int          wt[2];
        logic [1:0]  hit, got_resp;
        logic [31:0] got_rdata, seen_addr, seen_wdata;
        int          lat, avc;
        bit          done, aw_hs, w_hs, ar_hs;
        logic [1:0]  wr_hs_v, ar_hs_v, b_hs_v, r_hs_v;
        pb = '{1'b0, 1'b0}; pr = '{1'b0, 1'b0}; wt = '{0, 0};
        hit = 2'b00; got_resp = 2'b00; got_rdata = '0; seen_addr = '0; seen_wdata = '0;
        lat = -1; avc = 0; done = 1'b0;
        @(negedge clk);
        s_awaddr = v.addr; s_araddr = v.addr; s_wdata = v.data; s_wstrb = 4'hF;
        s_awvalid = v.wr; s_wvalid = v.wr; s_arvalid = ~v.wr; s_bready = 1'b1; s_rready = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            m0_awready = ~v.stall; m0_arready = ~v.stall; m0_wready = ~v.stall;
            m1_awready = ~v.stall; m1_arready = ~v.stall; m1_wready = ~v.stall;
            m0_bvalid = pb[0] && (wt[0] >= v.waits); m1_bvalid = pb[1] && (wt[1] >= v.waits);
            m0_rvalid = pr[0] && (wt[0] >= v.waits); m1_rvalid = pr[1] && (wt[1] >= v.waits);
            m0_bresp = v.sresp; m1_bresp = v.sresp; m0_rresp = v.sresp; m1_rresp = v.sresp;
            m0_rdata = v.sdata; m1_rdata = v.sdata;
            #1;
            hit[0] = hit[0] | m0_awvalid | m0_arvalid | m0_wvalid | m0_bready | m0_rready
                     | (|m0_awaddr) | (|m0_araddr) | (|m0_wdata) | (|m0_wstrb);
            hit[1] = hit[1] | m1_awvalid | m1_arvalid | m1_wvalid | m1_bready | m1_rready
                     | (|m1_awaddr) | (|m1_araddr) | (|m1_wdata) | (|m1_wstrb);
            avc += int'(m0_awvalid | m0_arvalid | m1_awvalid | m1_arvalid);
            if (m0_awvalid) seen_addr = m0_awaddr;
            if (m1_awvalid) seen_addr = m1_awaddr;
            if (m0_arvalid) seen_addr = m0_araddr;
            if (m1_arvalid) seen_addr = m1_araddr;
            if (m0_wvalid)  seen_wdata = m0_wdata;
            if (m1_wvalid)  seen_wdata = m1_wdata;
            if (s_bvalid && s_bready) begin got_resp = s_bresp; lat = c; done = 1'b1; end
            if (s_rvalid && s_rready) begin got_resp = s_rresp; got_rdata = s_rdata; lat = c; done = 1'b1; end
            aw_hs = s_awvalid & s_awready; w_hs = s_wvalid & s_wready; ar_hs = s_arvalid & s_arready;
            wr_hs_v = {m1_wvalid & m1_wready, m0_wvalid & m0_wready};
            ar_hs_v = {m1_arvalid & m1_arready, m0_arvalid & m0_arready};
            b_hs_v  = {m1_bvalid & m1_bready, m0_bvalid & m0_bready};
            r_hs_v  = {m1_rvalid & m1_rready, m0_rvalid & m0_rready};
            for (int n = 0; n < 2; n++) begin
                if (wr_hs_v[n]) begin pb[n] = 1'b1; wt[n] = 0; end
                else if (ar_hs_v[n]) begin pr[n] = 1'b1; wt[n] = 0; end
                else if (b_hs_v[n] || r_hs_v[n]) begin pb[n] = 1'b0; pr[n] = 1'b0; end
                else if (pb[n] || pr[n]) wt[n]++;
            end
            @(negedge clk);
            if (aw_hs) s_awvalid = 1'b0;
            if (w_hs)  s_wvalid = 1'b0;
            if (ar_hs) s_arvalid = 1'b0;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
        m0_awready = 1'b0; m0_arready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b0; m0_rvalid = 1'b0;
        m1_awready = 1'b0; m1_arready = 1'b0; m1_wready = 1'b0; m1_bvalid = 1'b0; m1_rvalid = 1'b0;
        #1;
        chk($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d_route", idx), 32'(hit), 32'(v.exp_hit));
        chk($sformatf("v%0d_resp", idx), 32'(got_resp), 32'(v.exp_resp));
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_addr_valid_cycles", idx), 32'(avc), 32'(v.exp_avc));
        chk($sformatf("v%0d_decerr_count", idx), 32'(decerr_count), 32'(v.exp_dec));
        chk($sformatf("v%0d_timeout_count", idx), 32'(timeout_count), 32'(v.exp_tmo));
        chk($sformatf("v%0d_busy_after", idx), 32'(busy), 32'd0);
        if (!v.wr) chk($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
        if (v.exp_hit != 2'b00) chk($sformatf("v%0d_slave_addr", idx), seen_addr, v.addr);
        if (v.wr && !v.stall && v.exp_hit != 2'b00) chk($sformatf("v%0d_slave_wdata", idx), seen_wdata, v.data);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_wr[3];
        bit drained;
        exp_wr = '{1'b1, 1'b0, 1'b1};
        //          wr    addr           data           wt stall sresp  sdata          hit    resp   rdata          lat avc dec    tmo
        vecs[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 0, 1'b0, 2'b00, 32'h0,         2'b01, 2'b00, 32'h0,         3,  1,  8'd0, 8'd0};
        vecs[1] = '{1'b0, 32'h0000_2008, 32'h0,         3, 1'b0, 2'b00, 32'h1234_5678, 2'b10, 2'b00, 32'h1234_5678, 5,  1,  8'd0, 8'd0};
        vecs[2] = '{1'b1, 32'h0000_5000, 32'h1111_1111, 0, 1'b0, 2'b00, 32'h0,         2'b00, 2'b11, 32'h0,         2,  0,  8'd1, 8'd0};
        vecs[3] = '{1'b0, 32'h0000_5000, 32'h0,         0, 1'b0, 2'b00, 32'hAAAA_AAAA, 2'b00, 2'b11, 32'h0,         1,  0,  8'd2, 8'd0};
        vecs[4] = '{1'b0, 32'h0000_1000, 32'h0,         0, 1'b1, 2'b00, 32'h5555_5555, 2'b01, 2'b10, 32'h0,         17, 16, 8'd2, 8'd1};
        vecs[5] = '{1'b1, 32'h0000_2FFC, 32'h0BAD_F00D, 2, 1'b0, 2'b10, 32'h0,         2'b10, 2'b10, 32'h0,         5,  1,  8'd2, 8'd1};
        vecs[6] = '{1'b0, 32'h0000_1FFC, 32'h0,         0, 1'b0, 2'b01, 32'hCAFE_F00D, 2'b01, 2'b01, 32'hCAFE_F00D, 2,  1,  8'd2, 8'd1};
        vecs[7] = '{1'b1, 32'h0000_0FFC, 32'h2222_2222, 0, 1'b0, 2'b00, 32'h0,         2'b00, 2'b11, 32'h0,         2,  0,  8'd3, 8'd1};
        vecs[8] = '{1'b0, 32'h0000_3000, 32'h0,         0, 1'b0, 2'b00, 32'hBBBB_BBBB, 2'b00, 2'b11, 32'h0,         1,  0,  8'd4, 8'd1};
        vecs[9] = '{1'b1, 32'h0000_2000, 32'h3333_3333, 0, 1'b1, 2'b00, 32'h0,         2'b10, 2'b10, 32'h0,         18, 16, 8'd4, 8'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_decerr", 32'(decerr_count), 32'd0);
        chk("reset_timeout", 32'(timeout_count), 32'd0);
        chk("reset_valids", 32'({s_bvalid, s_rvalid, s_awready, s_arready, s_wready, m0_awvalid, m1_awvalid, m0_arvalid, m1_arvalid}), 32'd0);
        chk("reset_resp_data", {s_bresp, s_rresp, s_rdata[27:0]}, 32'd0);

        for (int i = 0; i < 10; i++) run_txn(i, vecs[i]);

        // Reset while the write sits in WR_DATA with the slave stalling wready
        @(negedge clk);
        s_awaddr = 32'h0000_1004; s_awvalid = 1'b1; s_wdata = 32'h0102_0304; s_wstrb = 4'hF; s_wvalid = 1'b1;
        m0_awready = 1'b1; m0_wready = 1'b0;
        @(negedge clk);
        s_awvalid = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_pre_wvalid", 32'(m0_wvalid), 32'd1);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_post_busy", 32'(busy), 32'd0);
        chk("rst_post_wvalid", 32'(m0_wvalid), 32'd0);
        chk("rst_post_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_post_decerr", 32'(decerr_count), 32'd0);
        chk("rst_post_timeout", 32'(timeout_count), 32'd0);
        s_wvalid = 1'b0; m0_awready = 1'b0;

        // Contention right after reset: write, read, write
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            s_awaddr = 32'h0000_5000; s_araddr = 32'h0000_5000;
            s_awvalid = 1'b1; s_arvalid = 1'b1; s_wvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;
            #1;
            chk($sformatf("arb%0d_awready", r), 32'(s_awready), 32'(exp_wr[r]));
            chk($sformatf("arb%0d_arready", r), 32'(s_arready), 32'(!exp_wr[r]));
            @(negedge clk);
            s_awvalid = 1'b0; s_arvalid = 1'b0; s_wvalid = 1'b1;
            drained = 1'b0;
            for (int k = 0; k < 8 && !drained; k++) begin
                #1;
                if (!busy) drained = 1'b1;
                else @(negedge clk);
            end
            chk($sformatf("arb%0d_drain", r), 32'(drained), 32'd1);
            s_wvalid = 1'b0;
        end
        chk("arb_decerr", 32'(decerr_count), 32'd3);

        // 300 decode-error reads: count must stop at 8'hFF
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            s_araddr = 32'h0000_5000; s_arvalid = 1'b1; s_rready = 1'b1;
            @(negedge clk);
            s_arvalid = 1'b0;
            if (n == 199) begin
                #1;
                chk("sat_mid_decerr", 32'(decerr_count), 32'd203);
            end
        end
        @(negedge clk);
        #1;
        chk("sat_decerr", 32'(decerr_count), 32'hFF);
        chk("sat_timeout", 32'(timeout_count), 32'd0);
        chk("sat_busy", 32'(busy), 32'd0);
        s_rready = 1'b0; s_bready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4l_addr_router.md
# axi4l_addr_router

AXI4-Lite 1-master / 2-slave address router inserted between the UART-AXI4 bridge AXI master port and its targets. Slave 0 is the register block; slave 1 is an expansion window. Unmapped addresses and hung slaves are answered locally, so the bridge always receives a response.

- Single outstanding transaction.
- Write/read round-robin arbitration.
- Registered decode.
- Per-transaction timeout.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width (all ports).
- DATA_WIDTH, 32, data width; strobe width DATA_WIDTH/8.
- S0_BASE, 32'h0000_1000, slave 0 base (size-aligned).
- S0_SIZE, 32'h0000_1000, slave 0 window bytes (power of two).
- S1_BASE, 32'h0000_2000, slave 1 base.
- S1_SIZE, 32'h0000_1000, slave 1 window bytes.
- TIMEOUT_CYCLES, 1000, idle cycles allowed per slave-side phase (≥2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  upstream write address.
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  upstream write data.
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  upstream write response.
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  upstream read address.
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_WIDTH/2/1/1  upstream read data.
- mN_aw*, mN_w*, mN_b*, mN_ar*, mN_r* (N=0,1)  mirror of the s_* set, opposite direction  downstream slave N.
- busy  output  1  high whenever state ≠ IDLE.
- decerr_count  output  8  saturating count of decode errors.
- timeout_count  output  8  saturating count of timeouts.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, ERR_WDATA, ERR_BRESP, ERR_RRESP.
- Decode: hit N when (addr & ~(SN_SIZE-1)) == SN_BASE. Slave 0 wins if both windows match.
- Arbitration in IDLE:
  - Only one valid: grant it.
  - Both valid: grant the opposite of last_grant. last_grant resets to "read", so the first contention goes to write.
- Grant cycle (IDLE):
  - s_awready or s_arready = 1 combinationally.
  - Latch address and target; update last_grant.
  - Hit → WR_ADDR / RD_ADDR.
  - Miss → ERR_WDATA (write) or ERR_RRESP (read); decerr_count++.
- WR_ADDR:
  - mN_awvalid=1 with latched address.
  - On mN_awready → WR_DATA.
- WR_DATA:
  - mN_wvalid=s_wvalid; s_wready=mN_wready; data/strobe passed through.
  - On handshake → WR_RESP.
- WR_RESP:
  - s_bvalid=mN_bvalid; s_bresp=mN_bresp; mN_bready=s_bready.
  - On handshake → IDLE.
- RD_ADDR:
  - mN_arvalid=1.
  - On mN_arready → RD_DATA.
- RD_DATA:
  - s_rvalid/s_rdata/s_rresp ← slave N; mN_rready=s_rready.
  - On handshake → IDLE.
- ERR_WDATA:
  - s_wready=1; beat discarded.
  - On s_wvalid → ERR_BRESP.
- ERR_BRESP:
  - s_bvalid=1 with the pending code: DECERR 2'b11 for a decode miss, SLVERR 2'b10 after a timeout.
  - On s_bready → IDLE.
- ERR_RRESP:
  - s_rvalid=1, s_rdata=0, s_rresp = pending code as in ERR_BRESP.
  - On s_rready → IDLE.
- Non-selected slave and all idle-side valids/readies: 0.
- Timeout:
  - Counter clears on every state change.
  - It counts in WR_ADDR, RD_ADDR and while the awaited slave valid/ready is low in WR_DATA/WR_RESP/RD_DATA.
  - At TIMEOUT_CYCLES: drop all mN_* valids; timeout_count++; pending code = SLVERR.
  - WR_ADDR/WR_DATA → ERR_WDATA. If the W beat has already been accepted, go to ERR_BRESP.
  - WR_RESP → ERR_BRESP. RD_* → ERR_RRESP.
- Counters saturate at 8'hFF. No wrap.

## Timing
- Reset values: all valids/readies 0, s_bresp=0, s_rresp=0, s_rdata=0, busy=0, both counters 0, state IDLE.
- Reset mid-transaction: returns to IDLE next edge. Pending transfer abandoned; no response issued.
- Address latency: s_awvalid accepted at cycle T; mN_awvalid high from T+1.
- Zero-wait slave write: s_bvalid earliest at T+3.
- Zero-wait slave read: s_rvalid earliest at T+2.
- Decode-error write: s_bvalid one cycle after the W beat is accepted.
- Decode-error read: s_rvalid at T+1.
- W, B and R paths are combinational passthrough in their states. AW/AR are registered.
- s_awready and s_arready are never both high in the same cycle. Neither is asserted outside IDLE.

## Test plan
- Write 0x0000_1004 data 0xDEADBEEF, zero-wait slave → m0_awaddr 0x1004 at T+1, m0_wdata 0xDEADBEEF, s_bresp 2'b00; m1_* all 0 throughout.
- Read 0x0000_2008, slave 1 returns 0x12345678 after 3 waits → s_rdata 0x12345678, s_rresp 2'b00; busy high from T+1 until the R handshake.
- Write to 0x0000_5000 → no mN valid ever; s_wready=1, s_bresp 2'b11; decerr_count 0→1. Read to the same address → s_rdata 0, s_rresp 2'b11.
- awvalid and arvalid asserted together three times back-to-back → grant order write, read, write.
- Slave 0 holds m0_arready=0, TIMEOUT_CYCLES=16 → m0_arvalid drops after 16 cycles; s_rresp 2'b10; timeout_count=1.
- 300 decode errors → decerr_count holds 8'hFF. rst asserted in WR_DATA → next cycle IDLE, busy 0, counters 0.
